// File: rtl/divide_fix_pkg.sv
// Shared types and width helpers for the iterative fixed-point divider.
package divide_fix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DBZ_FLAG = 1'b1;

    function automatic int q_width(input int a_w, input int frac_w);
        return a_w + frac_w;
    endfunction

    function automatic int cnt_width(input int q_w);
        return $clog2(q_w + 1);
    endfunction

endpackage

// File: rtl/divide_fix_core_iter.sv
// Radix-2 restoring divider: one quotient bit per busy cycle, MSB first.
module divide_fix_core_iter
    import divide_fix_pkg::*;
#(
    parameter int A_W    = 40,
    parameter int B_W    = 8,
    parameter int FRAC_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [A_W-1:0]                 a,
    input  logic [B_W-1:0]                 b,
    output logic                           busy,
    output logic                           done,
    output logic [q_width(A_W, FRAC_W)-1:0] q,
    output logic                           dbz
);

    localparam int Q_W   = q_width(A_W, FRAC_W);
    localparam int CNT_W = cnt_width(Q_W);

    // Quotient bits shift into the low end of the dividend register as it empties.
    logic [Q_W-1:0]   dvd;
    logic [B_W:0]     rem;
    logic [B_W-1:0]   dsr;
    logic [CNT_W-1:0] cnt;
    logic [B_W:0]     rem_sh;
    logic             ge;

    assign rem_sh = {rem[B_W-1:0], dvd[Q_W-1]};
    assign ge     = (rem_sh >= {1'b0, dsr});
    assign q      = dvd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd  <= '0;
            rem  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            dbz  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                dvd  <= {a, {FRAC_W{1'b0}}};
                rem  <= '0;
                dsr  <= b;
                dbz  <= (b == '0);
                cnt  <= CNT_W'(Q_W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= ge ? (rem_sh - {1'b0, dsr}) : rem_sh;
                dvd <= {dvd[Q_W-2:0], ge};
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/divide_fix_iter_axis.sv
// Stream-handshaked fixed-point divider: FSM, result formatting and zero clamp around the core.
module divide_fix_iter_axis
    import divide_fix_pkg::*;
#(
    parameter int A_W         = 40,
    parameter int B_W         = 8,
    parameter int FRAC_W      = 8,
    parameter int OUT_W       = 64,
    parameter int OUT_SHIFT   = 12,
    parameter bit ZERO_TO_ONE = 1'b1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_axis_a_tvalid,
    input  logic [A_W-1:0]   s_axis_a_tdata,
    input  logic             s_axis_b_tvalid,
    input  logic [B_W-1:0]   s_axis_b_tdata,
    output logic             s_axis_tready,
    output logic             m_axis_result_tvalid,
    input  logic             m_axis_result_tready,
    output logic [OUT_W-1:0] m_axis_result_tdata,
    output logic             m_axis_result_tuser
);

    localparam int Q_W = q_width(A_W, FRAC_W);

    if (Q_W + OUT_SHIFT > OUT_W) begin : g_width_check
        $error("divide_fix_iter_axis: shifted quotient does not fit in OUT_W");
    end

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // both input channels share one ready and are consumed together or not at all.
    state_t           state;
    logic             accept;
    logic             core_busy;
    logic             core_done;
    logic [Q_W-1:0]   core_q;
    logic             core_dbz;
    logic [Q_W-1:0]   q_sel;
    logic [OUT_W-1:0] r_shift;
    logic [OUT_W-1:0] r_fmt;

    assign s_axis_tready = (state == IDLE) & aresetn;
    assign accept        = s_axis_a_tvalid & s_axis_b_tvalid & s_axis_tready;

    divide_fix_core_iter #(
        .A_W    (A_W),
        .B_W    (B_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .clk   (aclk),
        .rst_n (aresetn),
        .start (accept),
        .a     (s_axis_a_tdata),
        .b     (s_axis_b_tdata),
        .busy  (core_busy),
        .done  (core_done),
        .q     (core_q),
        .dbz   (core_dbz)
    );

    always_comb begin
        q_sel   = core_dbz ? '1 : core_q;
        r_shift = OUT_W'(q_sel) << OUT_SHIFT;
        r_fmt   = r_shift;
        if (ZERO_TO_ONE && (r_shift == '0)) begin
            r_fmt = OUT_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state                <= IDLE;
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= '0;
            m_axis_result_tuser  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !core_busy) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (core_done) begin
                        state                <= DONE;
                        m_axis_result_tvalid <= 1'b1;
                        m_axis_result_tdata  <= r_fmt;
                        m_axis_result_tuser  <= core_dbz ? DBZ_FLAG : 1'b0;
                    end
                end
                DONE: begin
                    if (m_axis_result_tready) begin
                        state                <= IDLE;
                        m_axis_result_tvalid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_fix_iter_axis.sv
// Randomized scoreboard bench for divide_fix_iter_axis against a plain-arithmetic divide model.
module tb_divide_fix_iter_axis;

    localparam int A_W = 40;
    localparam int B_W = 8;
    localparam int OUT_W = 64;
    localparam int LAT = 49;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             a_v = 1'b0;
    logic [A_W-1:0]   a_data = '0;
    logic             b_v = 1'b0;
    logic [B_W-1:0]   b_data = '0;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [OUT_W-1:0] m_data;
    logic             m_user;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    logic [OUT_W:0] exp_q[$];
    int acc_q[$];
    logic prev_valid = 1'b0;
    logic [OUT_W:0] hold_val = '0;

    divide_fix_iter_axis dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_a_tvalid      (a_v),
        .s_axis_a_tdata       (a_data),
        .s_axis_b_tvalid      (b_v),
        .s_axis_b_tdata       (b_data),
        .s_axis_tready        (s_ready),
        .m_axis_result_tvalid (m_valid),
        .m_axis_result_tready (m_ready),
        .m_axis_result_tdata  (m_data),
        .m_axis_result_tuser  (m_user)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [OUT_W:0] act, input logic [OUT_W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: Q = floor(A*2^8/B), all ones for B==0; result = Q<<12, zero clamped to 1.
    function automatic logic [OUT_W:0] model(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        logic [47:0] num;
        logic [47:0] q;
        logic [OUT_W-1:0] r;
        num = {a, 8'h00};
        if (b == 0) q = '1;
        else q = num / {40'd0, b};
        r = {16'd0, q} << 12;
        if (r == 0) r = 64'd1;
        return {(b == 0), r};
    endfunction

    // Expected entries are pushed at the accept edge; a reset edge discards them.
    always @(posedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            acc_q.delete();
        end else if (a_v && b_v && s_ready) begin
            exp_q.push_back(model(a_data, b_data));
            acc_q.push_back(cyc + 1);
        end
        cyc <= cyc + 1;
    end

    always @(negedge aclk) begin
        if (aresetn && m_valid) begin
            if (!prev_valid) begin
                hold_val = {m_user, m_data};
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    check("latency", OUT_W'(cyc), OUT_W'(acc_q[0] + LAT));
                end
            end else begin
                check("hold_stable", {m_user, m_data}, hold_val);
            end
            check("in_ready_busy", s_ready, 1'b0);
            if (m_ready && exp_q.size() > 0) begin
                check("result_tdata", m_data, exp_q[0][OUT_W-1:0]);
                check("result_tuser", m_user, exp_q[0][OUT_W]);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
        end
        prev_valid = aresetn && m_valid;
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        int n;
        n = 0;
        @(posedge aclk);
        #1;
        a_data = a;
        b_data = b;
        a_v = 1'b1;
        b_v = 1'b1;
        while (n < 500) begin
            @(negedge aclk);
            if (s_ready) break;
            n++;
        end
        if (n >= 500) check("accept_timeout", 1'b1, 1'b0);
        @(posedge aclk);
        #1;
        a_v = 1'b0;
        b_v = 1'b0;
        a_data = {8'($urandom), 32'($urandom)};
        b_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge aclk);
            if (s_ready && !m_valid) break;
            n++;
        end
        if (n >= 300) check("idle_timeout", 1'b1, 1'b0);
    endtask

    initial begin
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;
        int n;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_tvalid", m_valid, 1'b0);
        check("reset_tdata", m_data, '0);
        check("reset_tuser", m_user, 1'b0);
        check("reset_in_ready", s_ready, 1'b0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_reset_in_ready", s_ready, 1'b1);

        send(40'd100, 8'd4);
        send(40'd0, 8'd5);
        send(40'd7, 8'd0);
        send(40'hFF_FFFF_FFFF, 8'd1);
        send(40'd1, 8'd255);
        wait_idle();

        rdy_mode = 2;
        send(40'd123456, 8'd7);
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("bp_tvalid_seen", m_valid, 1'b1);
        repeat (10) @(negedge aclk);
        rdy_mode = 0;
        wait_idle();

        @(posedge aclk);
        #1;
        a_data = 40'd77;
        a_v = 1'b1;
        repeat (8) @(negedge aclk);
        check("a_only_no_accept", s_ready, 1'b1);
        send(40'd77, 8'd9);
        wait_idle();

        send(40'd55, 8'd3);
        repeat (27) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("abort_tvalid", m_valid, 1'b0);
        check("abort_in_ready", s_ready, 1'b1);
        repeat (60) @(negedge aclk);
        check("abort_no_result", m_valid, 1'b0);
        send(40'd9, 8'd3);
        wait_idle();

        rdy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            ra = {8'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) ra = 40'($urandom_range(0, 1000));
            rb = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            send(ra, rb);
        end
        rdy_mode = 0;

        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        check("drain_timeout", 1'(n >= 2000), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
